// File: rtl/membus_arbiter.sv
// membus_arbiter
//   Shares the single MMIO request bus between the instruction-fetch port (I)
//   and the data port (D). Each accepted request pushes its source and address
//   bit 2 into an in-order tag FIFO. Each memory response pops the head tag,
//   which steers the response to its requester. For I, the tag also selects the
//   32-bit half of the 64-bit read word.
//
//   Optional feature macro: MEMBUS_ARB_STARVE_GUARD_EN
//     When it is defined, I is forced to win once STARVE_LIMIT consecutive D
//     grants have gone by while I was waiting. When it is undefined, D always
//     has priority.
//
// Ports
//   clk, rst                 clock (rising edge); asynchronous active-low reset
//   i_valid/i_ready/i_addr   I request handshake and fetch address
//   i_rvalid/i_rdata         I response (selected 32-bit half)
//   d_valid/d_ready/d_addr/d_wen/d_wdata/d_wmask   D request
//   d_rvalid/d_rdata         D response (full word; writes respond too)
//   m_valid/m_ready/m_addr/m_wen/m_wdata/m_wmask   request to the MMIO controller
//   m_rvalid/m_rdata         MMIO response, in request order
//   outstanding              tag FIFO occupancy
//   err                      sticky protocol error (response with no tag)
module membus_arbiter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int ILEN            = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_valid,
  output logic                             i_ready,
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  output logic                             i_rvalid,
  output logic [ILEN-1:0]                  i_rdata,
  input  logic                             d_valid,
  output logic                             d_ready,
  input  logic [ADDR_WIDTH-1:0]            d_addr,
  input  logic                             d_wen,
  input  logic [DATA_WIDTH-1:0]            d_wdata,
  input  logic [DATA_WIDTH/8-1:0]          d_wmask,
  output logic                             d_rvalid,
  output logic [DATA_WIDTH-1:0]            d_rdata,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic                             m_wen,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  output logic [DATA_WIDTH/8-1:0]          m_wmask,
  input  logic                             m_rvalid,
  input  logic [DATA_WIDTH-1:0]            m_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             err
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] DEPTH = CW'(MAX_OUTSTANDING);

  // Tag storage: src 1 = D, 0 = I; half 1 = upper 32 bits of the word.
  logic [MAX_OUTSTANDING-1:0] src_q;
  logic [MAX_OUTSTANDING-1:0] half_q;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;

  logic empty, full, space, grant_i, force_i, push, pop;
  logic head_src, head_half;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ILEN-1:0] pick_half(input logic hi,
                                                input logic [DATA_WIDTH-1:0] w);
    return hi ? w[DATA_WIDTH-1:ILEN] : w[ILEN-1:0];
  endfunction

  assign empty = (count == '0);
  assign full  = (count == DEPTH);
  // A response retiring a tag this cycle frees a slot for a same-cycle push.
  assign space = !full || m_rvalid;

`ifdef MEMBUS_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign force_i = (starve_cnt >= SW'(STARVE_LIMIT));

  // Counts D acceptances that happened while I was waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!i_valid || i_ready) begin
      starve_cnt <= '0;
    end else if (d_ready) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // Guard compiled out: strict D priority, STARVE_LIMIT has no effect.
  assign force_i = (STARVE_LIMIT < 0);
`endif

  // ---- request path (combinational) ----
  assign grant_i = i_valid && (!d_valid || force_i);
  // Nothing is issued while reset is held.
  assign m_valid = rst && (i_valid || d_valid) && space;
  assign push    = m_valid && m_ready;
  assign i_ready = push && grant_i;
  assign d_ready = push && !grant_i;

  always_comb begin
    m_addr  = d_addr;
    m_wen   = d_wen;
    m_wdata = d_wdata;
    m_wmask = d_wmask;
    if (grant_i) begin
      m_addr  = i_addr;
      m_wen   = 1'b0;
      m_wdata = '0;
      m_wmask = '0;
    end
  end

  // ---- response path (combinational from head tag) ----
  assign head_src  = src_q[rd_ptr];
  assign head_half = half_q[rd_ptr];
  assign pop       = m_rvalid && !empty;

  assign d_rvalid    = pop && head_src;
  assign i_rvalid    = pop && !head_src;
  assign d_rdata     = m_rdata;
  assign i_rdata     = pick_half(head_half, m_rdata);
  assign outstanding = count;

  // ---- tag FIFO storage (data, not reset) ----
  always_ff @(posedge clk) begin
    if (push) begin
      src_q[wr_ptr]  <= !grant_i;
      half_q[wr_ptr] <= i_addr[2];
    end
  end

  // ---- tag FIFO control and error flag ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
      if ((m_rvalid && empty) || (push && full && !pop)) err <= 1'b1;
    end
  end

  no_overflow_push: assert property (@(posedge clk) disable iff (!rst)
    !(push && full && !pop));

endmodule

// File: tb/tb_membus_arbiter.sv
module tb_membus_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IL = 32;
  localparam int MO = 2;
  localparam int SL = 4;
`ifdef MEMBUS_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic i_valid, i_ready, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [IL-1:0] i_rdata;
  logic d_valid, d_ready, d_wen, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [DW/8-1:0] d_wmask;
  logic m_valid, m_ready, m_wen, m_rvalid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [DW/8-1:0] m_wmask;
  logic [$clog2(MO):0] outstanding;
  logic err;

  always #5 clk = ~clk;

  membus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ILEN(IL),
                   .MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wen(m_wen),
    .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .outstanding(outstanding), .err(err)
  );

  typedef struct { bit is_d; logic [63:0] data; } resp_t;
  typedef struct { logic [63:0] addr; bit wen; logic [63:0] wdata; logic [7:0] wmask; } dreq_t;

  resp_t       exp_q[$];   // expected responses in request order
  logic [63:0] mem_q[$];   // read words the memory model will return, in order
  logic [63:0] rd_ovr[$];  // directed read data overrides
  logic [63:0] i_pend[$];
  dreq_t       d_pend[$];

  int  n_vec = 0;
  int  n_err = 0;
  int  mdl_out = 0;
  bit  mdl_err = 0;
  int  starve = 0;
  int  p_mready = 100;
  int  p_resp = 0;
  bit  force_spur = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mdl_out = 0; mdl_err = 0; starve = 0;
    mem_q.delete(); exp_q.delete(); i_pend.delete(); d_pend.delete();
  endtask

  // One clock cycle: drive at negedge, predict and compare at negedge+1.
  task automatic cycle();
    bit space, g_i, exp_mv, acc_i, acc_d, popm;
    logic [63:0] rd;
    dreq_t dq;
    @(negedge clk);
    i_valid = (i_pend.size() > 0);
    i_addr  = i_valid ? i_pend[0] : {$urandom, $urandom};
    d_valid = (d_pend.size() > 0);
    if (d_valid) dq = d_pend[0];
    else dq = '{{$urandom, $urandom}, 1'b1, {$urandom, $urandom}, 8'($urandom)};
    d_addr = dq.addr; d_wen = dq.wen; d_wdata = dq.wdata; d_wmask = dq.wmask;
    m_ready  = ($urandom_range(99) < p_mready);
    m_rvalid = 1'b0;
    m_rdata  = {$urandom, $urandom};
    if (force_spur) m_rvalid = 1'b1;
    else if (mem_q.size() > 0 && $urandom_range(99) < p_resp) begin
      m_rvalid = 1'b1;
      m_rdata  = mem_q.pop_front();
    end
    #1;
    space  = (mdl_out < MO) || m_rvalid;
    g_i    = i_valid && (!d_valid || (GUARD && starve >= SL));
    exp_mv = (i_valid || d_valid) && space;
    acc_i  = exp_mv && m_ready && g_i;
    acc_d  = exp_mv && m_ready && !g_i;
    popm   = m_rvalid && (mdl_out > 0);
    check("m_valid", m_valid, exp_mv);
    check("i_ready", i_ready, acc_i);
    check("d_ready", d_ready, acc_d);
    check("outstanding", outstanding, mdl_out);
    check("err", err, mdl_err);
    check("rvalid_any", i_rvalid || d_rvalid, popm);
    if (exp_mv) begin
      check("m_addr",  m_addr,  g_i ? i_addr : d_addr);
      check("m_wen",   m_wen,   g_i ? 1'b0 : d_wen);
      check("m_wdata", m_wdata, g_i ? 64'd0 : d_wdata);
      check("m_wmask", m_wmask, g_i ? 8'd0 : d_wmask);
    end
    if (acc_i || acc_d) begin
      rd = (rd_ovr.size() > 0) ? rd_ovr.pop_front() : {$urandom, $urandom};
      mem_q.push_back(rd);
      if (acc_i) begin
        exp_q.push_back('{1'b0, i_addr[2] ? {32'd0, rd[63:32]} : {32'd0, rd[31:0]}});
        void'(i_pend.pop_front());
      end else begin
        exp_q.push_back('{1'b1, rd});
        void'(d_pend.pop_front());
      end
    end
    if (m_rvalid && mdl_out == 0) mdl_err = 1;
    mdl_out = mdl_out + int'(acc_i || acc_d) - int'(popm);
    if (acc_i || !i_valid) starve = 0;
    else if (acc_d) starve++;
  endtask

  // Response monitor: pops the scoreboard whenever the DUT delivers a response.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk); #2;
      if (i_rvalid && d_rvalid) check("both_rvalid", 1, 0);
      else if (i_rvalid || d_rvalid) begin
        if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("resp_src", d_rvalid, e.is_d);
          check("resp_data", d_rvalid ? d_rdata : {32'd0, i_rdata}, e.data);
        end
      end
    end
  end

  task automatic drain();
    p_resp = 100;
    for (int k = 0; k < 60 && (mdl_out > 0 || i_pend.size() > 0 || d_pend.size() > 0); k++)
      cycle();
    cycle();
    check("drain_outstanding", outstanding, 0);
    check("drain_scoreboard", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    i_valid = 1'b1; i_addr = '0; d_valid = 1'b0; d_addr = '0; d_wen = 1'b0;
    d_wdata = '0; d_wmask = '0; m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = '0;
    #3;
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_i_ready", i_ready, 0);
    check("rst_i_rvalid", i_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    @(negedge clk);
    i_valid = 1'b0; m_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // I-only fetch of the upper half.
    p_mready = 100; p_resp = 0;
    i_pend.push_back(64'h8000_0004);
    rd_ovr.push_back(64'h1111_2222_3333_4444);
    cycle();
    p_resp = 100;
    cycle();
    drain();

    // I and D together: D write first, then I.
    p_resp = 0;
    d_pend.push_back('{64'h10, 1'b1, 64'hDEAD_BEEF_0123_4567, 8'hFF});
    i_pend.push_back(64'h20);
    cycle();
    cycle();
    drain();

    // Fill to MAX_OUTSTANDING, stall, then pop and push in one cycle.
    p_resp = 0;
    i_pend.push_back(64'h0); i_pend.push_back(64'h4); i_pend.push_back(64'h8);
    cycle(); cycle(); cycle(); cycle();
    p_resp = 100;
    cycle();
    drain();

    // Reset while one request is outstanding.
    p_resp = 0;
    i_pend.push_back(64'h40);
    cycle();
    @(negedge clk); #1;
    rst = 1'b0; i_valid = 1'b1; d_valid = 1'b1; m_rvalid = 1'b0; m_ready = 1'b1;
    #1;
    check("async_rst_outstanding", outstanding, 0);
    check("async_rst_err", err, 0);
    check("async_rst_m_valid", m_valid, 0);
    check("async_rst_d_ready", d_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b0; d_valid = 1'b0;

    // Spurious response with an empty FIFO sets a sticky err.
    force_spur = 1;
    cycle();
    force_spur = 0;
    for (int k = 0; k < 3; k++) cycle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("err_cleared_by_rst", err, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Both requesters held busy.
    p_resp = 100; p_mready = 100;
    for (int k = 0; k < 8; k++) begin
      i_pend.push_back({$urandom, $urandom});
      d_pend.push_back('{{$urandom, $urandom}, 1'($urandom), {$urandom, $urandom}, 8'($urandom)});
    end
    for (int k = 0; k < 16; k++) cycle();
    drain();

    // Random traffic.
    p_mready = 70; p_resp = 50;
    for (int k = 0; k < 1500; k++) begin
      if (i_pend.size() < 2 && $urandom_range(99) < 45) i_pend.push_back({$urandom, $urandom});
      if (d_pend.size() < 2 && $urandom_range(99) < 45)
        d_pend.push_back('{{$urandom, $urandom}, 1'($urandom), {$urandom, $urandom}, 8'($urandom)});
      if (k % 300 == 299) p_resp = $urandom_range(20, 90);
      cycle();
    end
    p_mready = 100;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
